ingress_frame_gate: RTL and testbench

//   Store-and-forward gate between an rmii_port receive output and one core_data_orchestrator receive input.

---
 rtl/ingress_frame_gate_if.sv | 20 ++
 rtl/ingress_frame_gate.sv | 176 +++++++++++++++++
 tb/tb_ingress_frame_gate.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ingress_frame_gate_if.sv
// ----------------------------------------------------------------------------
// ingress_frame_gate_if
//   Byte-stream handshake used on both sides of ingress_frame_gate.
//   A word moves when valid && enable are both high on a rising clock edge.
//   Signals:
//     data    [8:0]  {last, byte}; bit 8 = 1 marks the final byte of a frame
//     valid          source has a word on data
//     enable         sink can accept the word (ready)
//   Modports:
//     master  drives data/valid, observes enable (stream source)
//     slave   observes data/valid, drives enable (stream sink)
// ----------------------------------------------------------------------------
interface ingress_frame_gate_if;
   logic [8:0] data;
   logic       valid;
   logic       enable;

   modport master (output data, output valid, input enable);
   modport slave  (input data, input valid, output enable);
endinterface

// File: rtl/ingress_frame_gate.sv
// ----------------------------------------------------------------------------
// ingress_frame_gate
//   Store-and-forward gate between the rmii_port receive stream and a
//   core_data_orchestrator receive input. Each frame is written into a
//   circular byte buffer and only made readable once it has ended with a
//   legal length. Runts, giants and frames that overflow the buffer are
//   discarded whole and counted, so the downstream side never sees a
//   partial frame.
//   Ports:
//     i_clock                single clock for the whole block
//     i_reset                synchronous reset, active-high
//     i_rx   (slave)         receive stream from rmii_port
//                            (data = receive_data, valid = receive_data_valid,
//                             enable = receive_data_enable, 1 except in reset)
//     o_tx   (master)        transmit stream to the orchestrator
//                            (data = transmit_data, valid = transmit_data_valid,
//                             enable = transmit_data_enable)
//     o_dropped_frame_count  frames discarded since reset, saturating
// ----------------------------------------------------------------------------
module ingress_frame_gate #(
   parameter int BUFFER_DEPTH    = 2048,
   parameter int MIN_FRAME_BYTES = 60,
   parameter int MAX_FRAME_BYTES = 1518
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   ingress_frame_gate_if.slave  i_rx,
   ingress_frame_gate_if.master o_tx,
   output logic [15:0]          o_dropped_frame_count
);
   localparam int AW = $clog2(BUFFER_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(BUFFER_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RECEIVE, S_DISCARD} state_t;

   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic len_too_long(input logic [10:0] len);
      return int'(len) > MAX_FRAME_BYTES;
   endfunction

   function automatic logic len_legal(input logic [10:0] len);
      return (int'(len) >= MIN_FRAME_BYTES) && (int'(len) <= MAX_FRAME_BYTES);
   endfunction

   logic [8:0]    r_mem [BUFFER_DEPTH];
   state_t        r_state;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_commit_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [10:0]   r_len;
   logic [15:0]   r_drop_cnt;
   logic [8:0]    r_tx_data;
   logic          r_tx_valid;

   logic [PW-1:0] w_used;
   logic          w_full;
   logic          w_last;
   logic [10:0]   w_len_inc;
   logic [PW-1:0] w_wr_ptr_inc;
   logic          w_we;
   logic          w_readable;
   logic          w_load;

   // Full uses the registered pointers, so a read in the same cycle does not
   // make room for the arriving byte.
   assign w_used       = r_wr_ptr - r_rd_ptr;
   assign w_full       = (w_used == DEPTH_P);
   assign w_last       = i_rx.data[8];
   assign w_len_inc    = sat_inc11(r_len);
   assign w_wr_ptr_inc = r_wr_ptr + PW'(1);

   // Bytes are stored in IDLE and RECEIVE unless there is no room or the frame
   // has just grown past the maximum; those bytes are thrown away.
   assign w_we = i_rx.valid && !i_reset && !w_full &&
                 ((r_state == S_IDLE) ||
                  ((r_state == S_RECEIVE) && !len_too_long(w_len_inc)));

   always_ff @(posedge i_clock) begin
      if (w_we) r_mem[r_wr_ptr[AW-1:0]] <= i_rx.data;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_len        <= '0;
         r_drop_cnt   <= '0;
      end else if (i_rx.valid) begin
         unique case (r_state)
            S_IDLE: begin
               r_len <= 11'd1;
               if (w_full) begin
                  // Buffer already holds only committed data: the whole frame overflows.
                  if (w_last) r_drop_cnt <= sat_inc16(r_drop_cnt);
                  else        r_state    <= S_DISCARD;
               end else if (w_last) begin
                  if (len_legal(11'd1)) begin
                     r_wr_ptr     <= w_wr_ptr_inc;
                     r_commit_ptr <= w_wr_ptr_inc;
                  end else begin
                     r_drop_cnt <= sat_inc16(r_drop_cnt);
                  end
               end else begin
                  r_wr_ptr <= w_wr_ptr_inc;
                  r_state  <= S_RECEIVE;
               end
            end
            S_RECEIVE: begin
               r_len <= w_len_inc;
               if (w_full || len_too_long(w_len_inc)) begin
                  // Rewind to the last committed frame; read side is untouched.
                  r_wr_ptr <= r_commit_ptr;
                  if (w_last) begin
                     r_drop_cnt <= sat_inc16(r_drop_cnt);
                     r_state    <= S_IDLE;
                  end else begin
                     r_state    <= S_DISCARD;
                  end
               end else if (w_last) begin
                  r_state <= S_IDLE;
                  if (len_legal(w_len_inc)) begin
                     r_wr_ptr     <= w_wr_ptr_inc;
                     r_commit_ptr <= w_wr_ptr_inc;
                  end else begin
                     r_wr_ptr   <= r_commit_ptr;
                     r_drop_cnt <= sat_inc16(r_drop_cnt);
                  end
               end else begin
                  r_wr_ptr <= w_wr_ptr_inc;
               end
            end
            S_DISCARD: begin
               if (w_last) begin
                  r_drop_cnt <= sat_inc16(r_drop_cnt);
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The synchronous RAM read lands directly in the output register, giving
   // first-word-fall-through: load when something is committed and the
   // register is empty or being drained this cycle; otherwise hold.
   assign w_readable = (r_rd_ptr != r_commit_ptr);
   assign w_load     = w_readable && (!r_tx_valid || o_tx.enable);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rd_ptr   <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
      end else if (w_load) begin
         r_tx_data  <= r_mem[r_rd_ptr[AW-1:0]];
         r_tx_valid <= 1'b1;
         r_rd_ptr   <= r_rd_ptr + PW'(1);
      end else if (o_tx.enable) begin
         r_tx_valid <= 1'b0;
      end
   end

   assign i_rx.enable           = ~i_reset;
   assign o_tx.data             = r_tx_data;
   assign o_tx.valid            = r_tx_valid;
   assign o_dropped_frame_count = r_drop_cnt;
endmodule

// File: tb/tb_ingress_frame_gate.sv
`timescale 1ns/1ps
module tb_ingress_frame_gate;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ingress_frame_gate_if a_rx ();
   ingress_frame_gate_if a_tx ();
   ingress_frame_gate_if b_rx ();
   ingress_frame_gate_if b_tx ();
   logic [15:0] a_drops;
   logic [15:0] b_drops;

   ingress_frame_gate u_dut_a (
      .i_clock(clk), .i_reset(rst), .i_rx(a_rx), .o_tx(a_tx),
      .o_dropped_frame_count(a_drops)
   );

   ingress_frame_gate #(
      .BUFFER_DEPTH(128), .MIN_FRAME_BYTES(60), .MAX_FRAME_BYTES(100)
   ) u_dut_b (
      .i_clock(clk), .i_reset(rst), .i_rx(b_rx), .o_tx(b_tx),
      .o_dropped_frame_count(b_drops)
   );

   int checks   = 0;
   int failures = 0;
   logic [8:0] exp_q[$];
   bit stall_mode = 1'b0;

   typedef struct {
      int len;
      int start;
      bit fwd;
      int drops;
   } vec_t;
   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (stall_mode) a_tx.enable = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input bit to_b, input int len, input int start, input bit with_last);
      for (int i = 0; i < len; i++) begin
         logic [8:0] w;
         w = {with_last && (i == len - 1), 8'(start + i)};
         if (to_b) begin b_rx.data = w; b_rx.valid = 1'b1; end
         else      begin a_rx.data = w; a_rx.valid = 1'b1; end
         tick();
      end
      a_rx.valid = 1'b0; a_rx.data = '0;
      b_rx.valid = 1'b0; b_rx.data = '0;
   endtask

   task automatic push_exp(input int len, input int start);
      for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, 8'(start + i)});
   endtask

   task automatic drain_a(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 8000) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
      repeat (3) tick();
   endtask

   // Scoreboard for instance A: every transfer must match the next expected
   // word, and a stalled word must not change.
   logic       stall_prev = 1'b0;
   logic [8:0] prev_data  = '0;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_hold_valid", a_tx.valid, 1);
            check("stall_hold_data", a_tx.data, prev_data);
         end
         if (a_tx.valid && a_tx.enable) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", a_tx.data, 9'h1FF);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("a_byte", a_tx.data, e);
            end
         end
         stall_prev = a_tx.valid && !a_tx.enable;
         prev_data  = a_tx.data;
      end
   end

   initial begin
      int cnt;
      int lastcnt;
      a_rx.data = '0; a_rx.valid = 1'b0; a_tx.enable = 1'b1;
      b_rx.data = '0; b_rx.valid = 1'b0; b_tx.enable = 1'b0;

      vecs[0] = '{64,   8'h00, 1'b1, 0};
      vecs[1] = '{20,   8'h20, 1'b0, 1};
      vecs[2] = '{60,   8'h90, 1'b1, 1};
      vecs[3] = '{1600, 8'h11, 1'b0, 2};
      vecs[4] = '{100,  8'h33, 1'b1, 2};
      vecs[5] = '{1,    8'h55, 1'b0, 3};
      vecs[6] = '{1518, 8'h07, 1'b1, 3};
      vecs[7] = '{1519, 8'h09, 1'b0, 4};
      vecs[8] = '{59,   8'hA0, 1'b0, 5};
      vecs[9] = '{61,   8'hC0, 1'b1, 5};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", a_tx.valid, 0);
      check("rst_tx_data", a_tx.data, 0);
      check("rst_drops", a_drops, 0);
      check("rst_rx_enable", a_rx.enable, 0);
      check("rst_b_tx_valid", b_tx.valid, 0);
      rst = 1'b0;
      tick();
      check("run_rx_enable", a_rx.enable, 1);

      // Table of frames on the default-size instance
      for (int v = 0; v < 10; v++) begin
         if (vecs[v].fwd) push_exp(vecs[v].len, vecs[v].start);
         send(1'b0, vecs[v].len, vecs[v].start, 1'b1);
         drain_a($sformatf("vec%0d_drain", v));
         check($sformatf("vec%0d_drops", v), a_drops, vecs[v].drops);
      end

      // Commit-to-valid latency
      push_exp(60, 8'h40);
      send(1'b0, 60, 8'h40, 1'b1);
      check("lat_commit_valid", a_tx.valid, 0);
      tick();
      check("lat_next_valid", a_tx.valid, 1);
      check("lat_first_byte", a_tx.data, 9'h040);
      drain_a("lat_drain");

      // Small buffer, output blocked: third frame overflows
      send(1'b1, 60, 8'h00, 1'b1);
      send(1'b1, 60, 8'h40, 1'b1);
      check("b_drops_two_frames", b_drops, 0);
      send(1'b1, 60, 8'h80, 1'b1);
      check("b_drops_overflow", b_drops, 1);
      check("b_held_valid", b_tx.valid, 1);
      check("b_held_data", b_tx.data, 9'h000);
      b_tx.enable = 1'b1;
      cnt = 0;
      lastcnt = 0;
      for (int c = 0; c < 300; c++) begin
         if (b_tx.valid) begin
            logic [8:0] e;
            if (cnt < 60) e = {cnt == 59, 8'(cnt)};
            else          e = {cnt == 119, 8'(8'h40 + cnt - 60)};
            if (cnt < 120) check("b_byte", b_tx.data, e);
            if (b_tx.data[8]) lastcnt++;
            cnt++;
         end
         tick();
      end
      check("b_out_bytes", cnt, 120);
      check("b_out_lasts", lastcnt, 2);

      // Reset in the middle of a frame
      send(1'b0, 30, 8'h10, 1'b0);
      a_rx.data = 9'h055; a_rx.valid = 1'b1;
      rst = 1'b1;
      tick();
      check("mid_rst_tx_valid", a_tx.valid, 0);
      check("mid_rst_tx_data", a_tx.data, 0);
      check("mid_rst_drops", a_drops, 0);
      check("mid_rst_rx_enable", a_rx.enable, 0);
      a_rx.valid = 1'b0; a_rx.data = '0;
      rst = 1'b0;
      tick();
      push_exp(60, 8'hE0);
      send(1'b0, 60, 8'hE0, 1'b1);
      drain_a("post_rst_drain");
      check("post_rst_drops", a_drops, 0);

      // Random output stalls over 50 legal frames
      stall_mode = 1'b1;
      for (int f = 0; f < 50; f++) begin
         int len;
         int n;
         len = 60 + (f * 13) % 41;
         n = 0;
         while (exp_q.size() > 500 && n < 8000) begin
            tick();
            n++;
         end
         push_exp(len, f * 5);
         send(1'b0, len, f * 5, 1'b1);
      end
      drain_a("stall_drain");
      stall_mode = 1'b0;
      a_tx.enable = 1'b1;
      check("stall_drops", a_drops, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
